// File: rtl/segasys1_video_pkg.sv
`timescale 1ns/1ps
// SEGA System 1 video timing defaults, IRQ state encoding and the modulo-add helper
// shared by the H/V timing generator and its window comparators.
package segasys1_video_pkg;

  localparam int unsigned HTOTAL_DEF   = 320;
  localparam int unsigned VTOTAL_DEF   = 260;
  localparam int unsigned HACTIVE_DEF  = 256;
  localparam int unsigned VACTIVE_DEF  = 224;
  localparam int unsigned HS_START_DEF = 280;
  localparam int unsigned HS_LEN_DEF   = 24;
  localparam int unsigned VS_START_DEF = 236;
  localparam int unsigned VS_LEN_DEF   = 3;
  localparam int unsigned IRQ_LEN_DEF  = 65;
  localparam int unsigned IRQ_CNT_W    = 7;

  typedef logic [IRQ_CNT_W-1:0] irq_cnt_t;

  // HOLD is the trigger-wins rule inside ASSERT; its encoding is reserved and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } irq_state_e;

  // base + small signed offset, folded back into [0, total); base must already be < total.
  function automatic logic [9:0] wrap_add(input logic [9:0] base,
                                          input logic [9:0] offs,
                                          input logic [9:0] total);
    logic [9:0] sum;
    sum = base + offs;
    if (offs[9] && (sum > base)) return sum + total;
    else if (sum >= total)       return sum - total;
    else                         return sum;
  endfunction

endpackage

// File: rtl/segasys1_hvt_window.sv
`timescale 1ns/1ps
// Modulo-wrapped window comparator: hit_o is 1 when pos_i lies in the LEN-long window
// starting at START+offs_i, with the window allowed to run across the TOTAL wrap point.
module segasys1_hvt_window
  import segasys1_video_pkg::*;
#(
  parameter int unsigned TOTAL = HTOTAL_DEF,
  parameter int unsigned START = HS_START_DEF,
  parameter int unsigned LEN   = HS_LEN_DEF
) (
  input  logic [8:0] pos_i,
  input  logic [3:0] offs_i,
  output logic       hit_o
);

  localparam logic [9:0] TOTAL_W = 10'(TOTAL);
  localparam logic [9:0] START_W = 10'(START);
  localparam logic [9:0] LEN_W   = 10'(LEN);

  logic [9:0] start_w;
  logic [9:0] pos_w;
  logic [9:0] dist_w;

  // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    start_w = wrap_add(START_W, {{6{offs_i[3]}}, offs_i}, TOTAL_W);
    pos_w   = {1'b0, pos_i};
    if (pos_w >= start_w) dist_w = pos_w - start_w;
    else                  dist_w = pos_w + TOTAL_W - start_w;
    hit_o = (dist_w < LEN_W);
  end

endmodule

// File: rtl/segasys1_hvtiming.sv
`timescale 1ns/1ps
// SEGA System 1 H/V video timing: pixel/line counters, blank and sync flags, VBLK IRQ.
// Define SEGASYS1_HVT_SHIFT_EN to add the HOFFS/VOFFS sync-offset ports (frame-start sampled).
module segasys1_hvtiming
  import segasys1_video_pkg::*;
#(
  parameter int unsigned HTOTAL   = HTOTAL_DEF,
  parameter int unsigned VTOTAL   = VTOTAL_DEF,
  parameter int unsigned HACTIVE  = HACTIVE_DEF,
  parameter int unsigned VACTIVE  = VACTIVE_DEF,
  parameter int unsigned HS_START = HS_START_DEF,
  parameter int unsigned HS_LEN   = HS_LEN_DEF,
  parameter int unsigned VS_START = VS_START_DEF,
  parameter int unsigned VS_LEN   = VS_LEN_DEF,
  parameter int unsigned IRQ_LEN  = IRQ_LEN_DEF
) (
  input  logic       VCLK,
  input  logic       RESET,
  input  logic       IRQ_ACK,
`ifdef SEGASYS1_HVT_SHIFT_EN
  input  logic [3:0] HOFFS,
  input  logic [3:0] VOFFS,
`endif
  output logic [8:0] PH,
  output logic [8:0] PV,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       VBLK_IRQ
);

  localparam irq_cnt_t IRQ_LAST = irq_cnt_t'(IRQ_LEN - 1);

  logic [8:0] ph_q, ph_d;
  logic [8:0] pv_q, pv_d;
  logic       ph_wrap;
  logic       hblank_q, vblank_q, hsync_q, vsync_q, irq_q;
  logic [3:0] hoffs_s, voffs_s;
  logic       h_hit, v_hit;
  logic [9:0] hs_pos;

  irq_state_e state_q, state_d;
  irq_cnt_t   cnt_q, cnt_d;
  logic       irq_d, trigger, timeout;

`ifdef SEGASYS1_HVT_SHIFT_EN
  logic [3:0] hoffs_q, voffs_q;

  // Offsets only move at frame start so a frame never sees a half-shifted sync.
  always_ff @(posedge VCLK or posedge RESET) begin
    if (RESET) begin
      hoffs_q <= '0;
      voffs_q <= '0;
    end else if (ph_q == '0 && pv_q == '0) begin
      hoffs_q <= HOFFS;
      voffs_q <= VOFFS;
    end
  end

  assign hoffs_s = hoffs_q;
  assign voffs_s = voffs_q;
`else
  assign hoffs_s = '0;
  assign voffs_s = '0;
`endif

  always_comb begin
    ph_wrap = (ph_q == 9'(HTOTAL - 1));
    ph_d    = ph_wrap ? '0 : ph_q + 9'd1;
    pv_d    = pv_q;
    if (ph_wrap) pv_d = (pv_q == 9'(VTOTAL - 1)) ? '0 : pv_q + 9'd1;
  end

  // Flags are computed from the next count so they land in the same cycle as PH/PV.
  segasys1_hvt_window #(.TOTAL(HTOTAL), .START(HS_START), .LEN(HS_LEN)) u_hwin (
    .pos_i  (ph_d),
    .offs_i (hoffs_s),
    .hit_o  (h_hit)
  );

  segasys1_hvt_window #(.TOTAL(VTOTAL), .START(VS_START), .LEN(VS_LEN)) u_vwin (
    .pos_i  (pv_d),
    .offs_i (voffs_s),
    .hit_o  (v_hit)
  );

  assign hs_pos = wrap_add(10'(HS_START), {{6{hoffs_s[3]}}, hoffs_s}, 10'(HTOTAL));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge VCLK or posedge RESET) begin
    if (RESET) begin
      ph_q     <= '0;
      pv_q     <= '0;
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      pv_q     <= pv_d;
      hblank_q <= (ph_d >= 9'(HACTIVE));
      vblank_q <= (pv_d >= 9'(VACTIVE));
      hsync_q  <= h_hit;
      if ({1'b0, ph_d} == hs_pos) vsync_q <= v_hit;
    end
  end

  // IRQ machine: state register.
  always_ff @(posedge VCLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

  // IRQ machine: next state. A frame trigger outranks acknowledge and timeout.
  always_comb begin
    trigger = (pv_q == 9'(VACTIVE)) && (ph_q == '0);
    timeout = (cnt_q >= IRQ_LAST);
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (trigger) state_d = ASSERT;
      ASSERT: begin
        if (trigger)                  state_d = ASSERT;
        else if (IRQ_ACK || timeout)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // IRQ machine: outputs and saturating timeout counter.
  always_comb begin
    irq_d = (state_d == ASSERT);
    cnt_d = '0;
    if (state_q == ASSERT && state_d == ASSERT && !trigger)
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  end

  assign PH       = ph_q;
  assign PV       = pv_q;
  assign HBLANK   = hblank_q;
  assign VBLANK   = vblank_q;
  assign HSYNC    = hsync_q;
  assign VSYNC    = vsync_q;
  assign VBLK_IRQ = irq_q;

endmodule

// File: tb/tb_segasys1_hvtiming.sv
`timescale 1ns/1ps
// Directed bench: a shrunken-frame instance for counters, flags, IRQ and reset, and a
// full-width short-frame instance for 320-pixel lines and the HSYNC wrap window.
module tb_segasys1_hvtiming;

  localparam int HT = 40, VT = 20, HA = 32, VA = 14;
  localparam int HS = 34, HL = 4, VS = 10, VL = 2, IL = 65;
  localparam int FR = HT * VT;
`ifdef SEGASYS1_HVT_SHIFT_EN
  localparam int H1 = HS - 8;
  localparam int V1 = VS + 7;
  localparam int WS = 310 + 7;
`else
  localparam int H1 = HS;
  localparam int V1 = VS;
  localparam int WS = 310;
`endif
  localparam int WE = WS + 24 - 1 - 320;
  localparam int VR = FR + V1 * HT + H1;
  localparam int VF = VR + VL * HT;
  localparam int RK = 3 * FR + VA * HT + H1 + 1;

  logic       VCLK = 1'b0;
  logic       RESET = 1'b1;
  logic       IRQ_ACK = 1'b0;
`ifdef SEGASYS1_HVT_SHIFT_EN
  logic [3:0] HOFFS = 4'd0, VOFFS = 4'd0;
  logic [3:0] w_hoffs = 4'd7, w_voffs = 4'd0;
`endif
  logic [8:0] ph, pv, w_ph, w_pv;
  logic       hblank, vblank, hsync, vsync, irq;
  logic       w_hblank, w_vblank, w_hsync, w_vsync, w_irq;

  int errors = 0;
  int checks = 0;
  int k = 0;

  segasys1_hvtiming #(
    .HTOTAL(HT), .VTOTAL(VT), .HACTIVE(HA), .VACTIVE(VA),
    .HS_START(HS), .HS_LEN(HL), .VS_START(VS), .VS_LEN(VL), .IRQ_LEN(IL)
  ) u_dut (
    .VCLK(VCLK), .RESET(RESET), .IRQ_ACK(IRQ_ACK),
`ifdef SEGASYS1_HVT_SHIFT_EN
    .HOFFS(HOFFS), .VOFFS(VOFFS),
`endif
    .PH(ph), .PV(pv), .HBLANK(hblank), .VBLANK(vblank),
    .HSYNC(hsync), .VSYNC(vsync), .VBLK_IRQ(irq)
  );

  segasys1_hvtiming #(
    .VTOTAL(2), .VACTIVE(1), .HS_START(310), .VS_START(0), .VS_LEN(1)
  ) u_wide (
    .VCLK(VCLK), .RESET(RESET), .IRQ_ACK(1'b0),
`ifdef SEGASYS1_HVT_SHIFT_EN
    .HOFFS(w_hoffs), .VOFFS(w_voffs),
`endif
    .PH(w_ph), .PV(w_pv), .HBLANK(w_hblank), .VBLANK(w_vblank),
    .HSYNC(w_hsync), .VSYNC(w_vsync), .VBLK_IRQ(w_irq)
  );

  always #5 VCLK = ~VCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %0d expected %0d", tag, k, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge VCLK);
    #1;
    k++;
  endtask

  task automatic go(input int target);
    while (k < target) tick();
  endtask

  initial begin
    repeat (3) tick();
    check("rst_ph", ph, 0);
    check("rst_pv", pv, 0);
    check("rst_hblank", hblank, 0);
    check("rst_vblank", vblank, 0);
    check("rst_hsync", hsync, 0);
    check("rst_vsync", vsync, 0);
    check("rst_irq", irq, 0);
    check("rst_w_ph", w_ph, 0);

    RESET = 1'b0;
    k = 0;
    go(1);    check("first_ph", ph, 1); check("first_pv", pv, 0); check("w_first_ph", w_ph, 1);
`ifdef SEGASYS1_HVT_SHIFT_EN
    HOFFS = 4'b1000;
    VOFFS = 4'b0111;
`endif
    go(31);   check("hblank_31", hblank, 0);
    go(32);   check("hblank_32", hblank, 1); check("ph_32", ph, 32);
    go(33);   check("hsync_33", hsync, 0);
    go(34);   check("hsync_34", hsync, 1);
    go(37);   check("hsync_37", hsync, 1);
    go(38);   check("hsync_38", hsync, 0);
    go(39);   check("ph_39", ph, 39); check("pv_line0", pv, 0);
    go(40);   check("ph_wrap", ph, 0); check("pv_line1", pv, 1); check("hblank_wrap", hblank, 0);

    go(255);  check("w_hblank_255", w_hblank, 0);
    go(256);  check("w_hblank_256", w_hblank, 1); check("w_ph_256", w_ph, 256);
    go(319);  check("w_ph_319", w_ph, 319);
    go(320);  check("w_ph_wrap", w_ph, 0); check("w_pv_1", w_pv, 1);

    go(433);  check("vsync_f0_pre", vsync, 0);
    go(434);  check("vsync_f0_rise", vsync, 1);
    go(513);  check("vsync_f0_hold", vsync, 1);
    go(514);  check("vsync_f0_fall", vsync, 0);

    go(559);  check("vblank_13", vblank, 0); check("pv_13", pv, 13);
    go(560);  check("vblank_14", vblank, 1); check("pv_14", pv, 14); check("irq_trig_cyc", irq, 0);
    go(561);  check("irq_rise", irq, 1);
    go(625);  check("irq_last", irq, 1);
    go(625 + 1); check("irq_timeout", irq, 0);

    go(640);  check("w_pv_wrap", w_pv, 0); check("w_ph_frame", w_ph, 0);

    go(FR - 1); check("ph_end", ph, HT - 1); check("pv_end", pv, VT - 1); check("vblank_end", vblank, 1);
    go(FR);     check("ph_frame", ph, 0); check("pv_wrap", pv, 0); check("vblank_frame", vblank, 0);

    go(FR + H1 - 1);  check("hsync_f1_pre", hsync, 0);
    go(FR + H1);      check("hsync_f1_rise", hsync, 1);
    go(FR + H1 + HL - 1); check("hsync_f1_last", hsync, 1);
    go(FR + H1 + HL); check("hsync_f1_fall", hsync, 0);

    go(640 + WS - 1); check("w_hsync_pre", w_hsync, 0);
    go(640 + WS);     check("w_hsync_rise", w_hsync, 1);
    go(959);          check("w_hsync_319", w_hsync, 1);
    go(960);          check("w_hsync_0", w_hsync, 1); check("w_ph_0", w_ph, 0);
    go(960 + WE);     check("w_hsync_end", w_hsync, 1);
    go(961 + WE);     check("w_hsync_fall", w_hsync, 0);

    go(VR - 1); check("vsync_f1_pre", vsync, 0);
    go(VR);     check("vsync_f1_rise", vsync, 1);
    go(VF - 1); check("vsync_f1_hold", vsync, 1);
    go(VF);     check("vsync_f1_fall", vsync, 0);

    go(FR * 2 - 10);
    IRQ_ACK = 1'b1;
    tick();
    IRQ_ACK = 1'b0;

    go(2 * FR + VA * HT);      check("irq_f2_trig", irq, 0);
    go(2 * FR + VA * HT + 1);  check("irq_f2_rise", irq, 1);
    go(2 * FR + VA * HT + 2);  check("irq_f2_kept", irq, 1);
    go(2 * FR + VA * HT + 11); check("irq_f2_preack", irq, 1);
    IRQ_ACK = 1'b1;
    tick();
    IRQ_ACK = 1'b0;
    check("irq_ack_drop", irq, 0);
    go(2 * FR + VA * HT + 40); check("irq_ack_stays", irq, 0);

    go(RK); check("pre_rst_irq", irq, 1); check("pre_rst_hsync", hsync, 1); check("pre_rst_vblank", vblank, 1);
    RESET = 1'b1;
    #1;
    check("async_ph", ph, 0);
    check("async_pv", pv, 0);
    check("async_hblank", hblank, 0);
    check("async_vblank", vblank, 0);
    check("async_hsync", hsync, 0);
    check("async_vsync", vsync, 0);
    check("async_irq", irq, 0);
    check("async_w_ph", w_ph, 0);
    check("async_w_hblank", w_hblank, 0);
    check("async_w_vblank", w_vblank, 0);
    check("async_w_hsync", w_hsync, 0);
    check("async_w_vsync", w_vsync, 0);
    check("async_w_irq", w_irq, 0);
    tick();
    tick();
    check("held_ph", ph, 0);
    check("held_irq", irq, 0);

    RESET = 1'b0;
    k = 0;
    go(VA * HT);     check("rerun_trig", irq, 0);
    go(VA * HT + 1); check("rerun_irq", irq, 1); check("rerun_pv", pv, VA); check("rerun_ph", ph, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
